// File: rtl/hht_mem_responder.sv
// hht_mem_responder
// Loads a column bank and a vector bank from a single load stream, then
// serves two independent combinational read ports over address windows.
//
// Ports
//   Clk, Rst            : clock, asynchronous active-high reset
//   cfg_we              : latch col_base / v_base / col_size and start a load
//   col_base, v_base    : first address of the column / vector window
//   col_size            : number of column words (1..COL_DEPTH)
//   ld_valid, ld_ready  : load beat handshake
//   ld_data, ld_last    : load word, final-beat marker
//   ready               : high while serving reads
//   addr1 / dataIn1     : column read port
//   addr2 / dataIn2     : vector read port
//   rd_cnt1, rd_cnt2    : saturating hit counters per port
//   err                 : sticky configuration / load framing error
module hht_mem_responder #(
    parameter int          COL_DEPTH = 512,
    parameter int          V_DEPTH   = 32,
    parameter logic [31:0] MISS_VAL  = 32'd99999
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        cfg_we,
    input  logic [31:0] col_base,
    input  logic [31:0] v_base,
    input  logic [31:0] col_size,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ready,
    input  logic [31:0] addr1,
    output logic [31:0] dataIn1,
    input  logic [31:0] addr2,
    output logic [31:0] dataIn2,
    output logic [15:0] rd_cnt1,
    output logic [15:0] rd_cnt2,
    output logic        err
);

    localparam int CAW = (COL_DEPTH > 1) ? $clog2(COL_DEPTH) : 1;
    localparam int VAW = (V_DEPTH > 1) ? $clog2(V_DEPTH) : 1;
    // The write pointer walks both banks, so it is sized for the larger one.
    localparam int PW  = (CAW > VAW) ? CAW : VAW;

    localparam logic [31:0]   COL_DEPTH_W = 32'(COL_DEPTH);
    localparam logic [31:0]   V_DEPTH_W   = 32'(V_DEPTH);
    localparam logic [PW-1:0] PTR_ZERO    = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE     = {{(PW-1){1'b0}}, 1'b1};

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LD_COL = 2'd1;
    localparam logic [1:0] ST_LD_V   = 2'd2;
    localparam logic [1:0] ST_SERVE  = 2'd3;

    logic [1:0]    state_r;
    logic [PW-1:0] wptr_r;
    logic [31:0]   col_base_r;
    logic [31:0]   v_base_r;
    logic [31:0]   col_size_r;
    logic [15:0]   rd_cnt1_r;
    logic [15:0]   rd_cnt2_r;
    logic          err_r;

    logic [31:0]   col_mem_r [COL_DEPTH];
    logic [31:0]   v_mem_r   [V_DEPTH];

    logic          serve_s;
    logic          loading_s;
    logic          beat_s;
    logic          cfg_ok_s;
    logic [31:0]   wptr_ext_s;
    logic          col_final_s;
    logic          v_final_s;
    logic [31:0]   off1_s;
    logic [31:0]   off2_s;
    logic          hit1_s;
    logic          hit2_s;
    logic [31:0]   data1_s;
    logic [31:0]   data2_s;

    assign serve_s     = (state_r == ST_SERVE);
    assign loading_s   = (state_r == ST_LD_COL) || (state_r == ST_LD_V);
    assign beat_s      = ld_valid && loading_s;
    assign cfg_ok_s    = (col_size != 32'd0) && (col_size <= COL_DEPTH_W);
    assign wptr_ext_s  = {{(32-PW){1'b0}}, wptr_r};
    assign col_final_s = (wptr_ext_s == (col_size_r - 32'd1));
    assign v_final_s   = (wptr_ext_s == (V_DEPTH_W - 32'd1));

    // Window decode and combinational read mux for both ports.
    always_comb begin
        // Unsigned subtraction makes a window that wraps past 2^32 decode correctly.
        off1_s  = addr1 - col_base_r;
        off2_s  = addr2 - v_base_r;
        hit1_s  = serve_s && (off1_s < col_size_r);
        hit2_s  = serve_s && (off2_s < V_DEPTH_W);
        if (hit1_s) begin
            data1_s = col_mem_r[off1_s[CAW-1:0]];
        end else begin
            data1_s = MISS_VAL;
        end
        if (hit2_s) begin
            data2_s = v_mem_r[off2_s[VAW-1:0]];
        end else begin
            data2_s = MISS_VAL;
        end
    end

    // Control FSM, configuration registers, write pointer, counters and error flag.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r    <= ST_IDLE;
            wptr_r     <= PTR_ZERO;
            col_base_r <= 32'd0;
            v_base_r   <= 32'd0;
            col_size_r <= 32'd0;
            rd_cnt1_r  <= 16'd0;
            rd_cnt2_r  <= 16'd0;
            err_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_SERVE: begin
                    if (cfg_we) begin
                        if (cfg_ok_s) begin
                            col_base_r <= col_base;
                            v_base_r   <= v_base;
                            col_size_r <= col_size;
                            wptr_r     <= PTR_ZERO;
                            rd_cnt1_r  <= 16'd0;
                            rd_cnt2_r  <= 16'd0;
                            err_r      <= 1'b0;
                            state_r    <= ST_LD_COL;
                        end else begin
                            err_r   <= 1'b1;
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        if (hit1_s && (rd_cnt1_r != 16'hFFFF)) begin
                            rd_cnt1_r <= rd_cnt1_r + 16'd1;
                        end
                        if (hit2_s && (rd_cnt2_r != 16'hFFFF)) begin
                            rd_cnt2_r <= rd_cnt2_r + 16'd1;
                        end
                    end
                end
                ST_LD_COL: begin
                    if (beat_s) begin
                        // Any ld_last inside the column phase is a framing error.
                        if (ld_last) begin
                            err_r <= 1'b1;
                        end
                        if (col_final_s) begin
                            wptr_r  <= PTR_ZERO;
                            state_r <= ST_LD_V;
                        end else begin
                            wptr_r <= wptr_r + PTR_ONE;
                        end
                    end
                end
                ST_LD_V: begin
                    if (beat_s) begin
                        // ld_last must appear on exactly the final vector beat.
                        if (ld_last != v_final_s) begin
                            err_r <= 1'b1;
                        end
                        if (v_final_s) begin
                            wptr_r  <= PTR_ZERO;
                            state_r <= ST_SERVE;
                        end else begin
                            wptr_r <= wptr_r + PTR_ONE;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Bank writes; contents survive reset and are only replaced by a new load.
    always_ff @(posedge Clk) begin
        if (beat_s && (state_r == ST_LD_COL)) begin
            col_mem_r[wptr_r[CAW-1:0]] <= ld_data;
        end
        if (beat_s && (state_r == ST_LD_V)) begin
            v_mem_r[wptr_r[VAW-1:0]] <= ld_data;
        end
    end

    assign ld_ready = loading_s;
    assign ready    = serve_s;
    assign dataIn1  = data1_s;
    assign dataIn2  = data2_s;
    assign rd_cnt1  = rd_cnt1_r;
    assign rd_cnt2  = rd_cnt2_r;
    assign err      = err_r;

endmodule

// File: tb/tb_hht_mem_responder.sv
// Directed bench for hht_mem_responder: load/serve, misses, bad config,
// reset mid-load, framing errors, counters with saturation, wrap-around.
module tb_hht_mem_responder;

    localparam logic [31:0] MISS = 32'd99999;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [31:0] col_base = 32'd0;
    logic [31:0] v_base = 32'd0;
    logic [31:0] col_size = 32'd0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [31:0] ld_data = 32'd0;
    logic        ld_last = 1'b0;
    logic        ready;
    logic [31:0] addr1 = 32'd0;
    logic [31:0] dataIn1;
    logic [31:0] addr2 = 32'd0;
    logic [31:0] dataIn2;
    logic [15:0] rd_cnt1;
    logic [15:0] rd_cnt2;
    logic        err;

    int checks = 0;
    int errors = 0;

    hht_mem_responder dut (
        .Clk(Clk), .Rst(Rst), .cfg_we(cfg_we), .col_base(col_base),
        .v_base(v_base), .col_size(col_size), .ld_valid(ld_valid),
        .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .ready(ready), .addr1(addr1), .dataIn1(dataIn1), .addr2(addr2),
        .dataIn2(dataIn2), .rd_cnt1(rd_cnt1), .rd_cnt2(rd_cnt2), .err(err)
    );

    always #5 Clk = ~Clk;

    // Column word patterns: kind 0 is the basic scenario (first 29, last 14 of 307).
    function automatic logic [31:0] col_word(input int kind, input int i);
        if (kind == 0) begin
            if (i == 0) return 32'd29;
            if (i == 306) return 32'd14;
            return 32'd1000 + 32'(i) * 32'd7;
        end
        return 32'd5000 + 32'(i) * 32'd3;
    endfunction

    // Vector word patterns: kind 0 has first 85, last 65.
    function automatic logic [31:0] v_word(input int kind, input int i);
        if (kind == 0) begin
            if (i == 0) return 32'd85;
            if (i == 31) return 32'd65;
            return 32'd500 + 32'(i);
        end
        return 32'd9000 + 32'(i) * 32'd11;
    endfunction

    // All drivers assume they are entered at posedge+1 and leave at posedge+1.
    task automatic do_cfg(input logic [31:0] cb, input logic [31:0] cs, input logic [31:0] vb);
        col_base = cb; col_size = cs; v_base = vb; cfg_we = 1'b1;
        @(posedge Clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        ld_valid = 1'b1; ld_data = d; ld_last = last;
        @(posedge Clk); #1;
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    // Full load with periodic stalls; last_ok=0 omits ld_last on the final beat.
    task automatic load_all(input int ncol, input int kind, input logic last_ok);
        int not_ready = 0;
        for (int i = 0; i < ncol; i++) begin
            if (i % 64 == 63) begin
                repeat (3) begin @(posedge Clk); #1; end
            end
            if (ld_ready !== 1'b1) not_ready++;
            beat(col_word(kind, i), 1'b0);
        end
        for (int i = 0; i < 32; i++) begin
            if (ld_ready !== 1'b1) not_ready++;
            beat(v_word(kind, i), (i == 31) ? last_ok : 1'b0);
        end
        checks++;
        if (not_ready != 0) begin
            errors++;
            $display("FAIL load_ld_ready: %0d beats saw ld_ready=0, expected 0", not_ready);
        end
    endtask

    task automatic test_reset;
        #2;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b exp 0", ready); end
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL rst_ld_ready: got %b exp 0", ld_ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", err); end
        checks++; if (rd_cnt1 !== 16'd0 || rd_cnt2 !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d/%0d exp 0/0", rd_cnt1, rd_cnt2); end
        checks++; if (dataIn1 !== MISS || dataIn2 !== MISS) begin errors++; $display("FAIL rst_data: got %0d/%0d exp 99999", dataIn1, dataIn2); end
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic test_bad_cfg;
        do_cfg(32'd0, 32'd0, 32'd0);
        checks++; if (err !== 1'b1 || ld_ready !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL bad_cfg_zero: err=%b ld_ready=%b ready=%b exp 1 0 0", err, ld_ready, ready); end
        do_cfg(32'd0, 32'd513, 32'd0);
        checks++; if (err !== 1'b1 || ld_ready !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL bad_cfg_513: err=%b ld_ready=%b ready=%b exp 1 0 0", err, ld_ready, ready); end
    endtask

    task automatic test_basic;
        do_cfg(32'd340, 32'd307, 32'd2);
        checks++; if (err !== 1'b0 || ld_ready !== 1'b1) begin errors++; $display("FAIL basic_cfg: err=%b ld_ready=%b exp 0 1", err, ld_ready); end
        addr1 = 32'd340; #1;
        checks++; if (dataIn1 !== MISS) begin errors++; $display("FAIL basic_load_miss: got %0d exp 99999", dataIn1); end
        load_all(307, 0, 1'b1);
        checks++; if (ready !== 1'b1 || err !== 1'b0 || ld_ready !== 1'b0) begin errors++; $display("FAIL basic_ready: ready=%b err=%b ld_ready=%b exp 1 0 0", ready, err, ld_ready); end
        addr1 = 32'd340; addr2 = 32'd2; #1;
        checks++; if (dataIn1 !== 32'd29) begin errors++; $display("FAIL basic_a340: got %0d exp 29", dataIn1); end
        checks++; if (dataIn2 !== 32'd85) begin errors++; $display("FAIL basic_a2: got %0d exp 85", dataIn2); end
        addr1 = 32'd646; addr2 = 32'd33; #1;
        checks++; if (dataIn1 !== 32'd14) begin errors++; $display("FAIL basic_a646: got %0d exp 14", dataIn1); end
        checks++; if (dataIn2 !== 32'd65) begin errors++; $display("FAIL basic_a33: got %0d exp 65", dataIn2); end
        addr1 = 32'd400; addr2 = 32'd10; #1;
        checks++; if (dataIn1 !== col_word(0, 60) || dataIn2 !== v_word(0, 8)) begin errors++; $display("FAIL basic_mid: got %0d/%0d exp %0d/%0d", dataIn1, dataIn2, col_word(0, 60), v_word(0, 8)); end
        addr1 = 32'd0; addr2 = 32'd0;
        @(posedge Clk); #1;
    endtask

    task automatic test_misses;
        logic [31:0] m1 [2];
        logic [31:0] m2 [2];
        logic [15:0] c1, c2;
        m1[0] = 32'd339; m1[1] = 32'd647;
        m2[0] = 32'd1;   m2[1] = 32'd34;
        c1 = rd_cnt1; c2 = rd_cnt2;
        for (int k = 0; k < 2; k++) begin
            addr1 = m1[k]; addr2 = m2[k]; #1;
            checks++; if (dataIn1 !== MISS || dataIn2 !== MISS) begin errors++; $display("FAIL miss_data_%0d: got %0d/%0d exp 99999", k, dataIn1, dataIn2); end
            @(posedge Clk); #1;
            checks++; if (rd_cnt1 !== c1 || rd_cnt2 !== c2) begin errors++; $display("FAIL miss_cnt_%0d: got %0d/%0d exp %0d/%0d", k, rd_cnt1, rd_cnt2, c1, c2); end
        end
        addr1 = 32'd0; addr2 = 32'd0;
    endtask

    task automatic test_reset_midload;
        do_cfg(32'd340, 32'd307, 32'd2);
        for (int i = 0; i < 100; i++) beat(col_word(1, i), 1'b0);
        Rst = 1'b1; addr1 = 32'd340; #1;
        checks++; if (ld_ready !== 1'b0 || ready !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rstmid_flags: ld_ready=%b ready=%b err=%b exp 0 0 0", ld_ready, ready, err); end
        checks++; if (dataIn1 !== MISS || rd_cnt1 !== 16'd0) begin errors++; $display("FAIL rstmid_data: got %0d cnt %0d exp 99999 0", dataIn1, rd_cnt1); end
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(posedge Clk); #1;
        do_cfg(32'd340, 32'd307, 32'd2);
        load_all(307, 1, 1'b1);
        addr1 = 32'd490; addr2 = 32'd22; #1;
        checks++; if (ready !== 1'b1 || dataIn1 !== col_word(1, 150) || dataIn2 !== v_word(1, 20)) begin errors++; $display("FAIL rstmid_reload: ready=%b got %0d/%0d exp 1 %0d/%0d", ready, dataIn1, dataIn2, col_word(1, 150), v_word(1, 20)); end
        addr1 = 32'd0; addr2 = 32'd0;
    endtask

    task automatic test_ld_last_err;
        do_cfg(32'd100, 32'd1, 32'd200);
        beat(32'd77, 1'b1);
        checks++; if (err !== 1'b1 || ld_ready !== 1'b1) begin errors++; $display("FAIL early_last: err=%b ld_ready=%b exp 1 1", err, ld_ready); end
        for (int i = 0; i < 32; i++) beat(v_word(1, i), i == 31);
        addr1 = 32'd100; #1;
        checks++; if (ready !== 1'b1 || err !== 1'b1 || dataIn1 !== 32'd77) begin errors++; $display("FAIL size1_serve: ready=%b err=%b got %0d exp 1 1 77", ready, err, dataIn1); end
        addr1 = 32'd0;
        do_cfg(32'd100, 32'd32, 32'd100);
        checks++; if (err !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL cfg_clear_err: err=%b ready=%b exp 0 0", err, ready); end
        load_all(32, 1, 1'b0);
        checks++; if (err !== 1'b1 || ready !== 1'b1) begin errors++; $display("FAIL missing_last: err=%b ready=%b exp 1 1", err, ready); end
    endtask

    task automatic test_counters;
        do_cfg(32'd100, 32'd32, 32'd100);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL serve_cfg_ready: got %b exp 0", ready); end
        load_all(32, 1, 1'b1);
        checks++; if (err !== 1'b0 || rd_cnt1 !== 16'd0 || rd_cnt2 !== 16'd0) begin errors++; $display("FAIL cnt_start: err=%b cnt %0d/%0d exp 0 0/0", err, rd_cnt1, rd_cnt2); end
        addr1 = 32'd100; addr2 = 32'd131;
        repeat (10) begin @(posedge Clk); #1; end
        addr1 = 32'd0; addr2 = 32'd0; #1;
        checks++; if (rd_cnt1 !== 16'd10 || rd_cnt2 !== 16'd10) begin errors++; $display("FAIL cnt_10: got %0d/%0d exp 10/10", rd_cnt1, rd_cnt2); end
        addr1 = 32'd105; addr2 = 32'd105; #1;
        checks++; if (dataIn1 !== col_word(1, 5) || dataIn2 !== v_word(1, 5)) begin errors++; $display("FAIL overlap_same: got %0d/%0d exp %0d/%0d", dataIn1, dataIn2, col_word(1, 5), v_word(1, 5)); end
        addr1 = 32'd131; addr2 = 32'd132; #1;
        checks++; if (dataIn1 !== col_word(1, 31) || dataIn2 !== MISS) begin errors++; $display("FAIL overlap_edge: got %0d/%0d exp %0d/99999", dataIn1, dataIn2, col_word(1, 31)); end
        addr1 = 32'd100; addr2 = 32'd100;
        repeat (65540) begin @(posedge Clk); #1; end
        checks++; if (rd_cnt1 !== 16'hFFFF || rd_cnt2 !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat: got %h/%h exp ffff/ffff", rd_cnt1, rd_cnt2); end
        repeat (5) begin @(posedge Clk); #1; end
        checks++; if (rd_cnt1 !== 16'hFFFF || rd_cnt2 !== 16'hFFFF) begin errors++; $display("FAIL cnt_hold: got %h/%h exp ffff/ffff", rd_cnt1, rd_cnt2); end
        addr1 = 32'd0; addr2 = 32'd0;
    endtask

    task automatic test_wrap;
        do_cfg(32'hFFFF_FFF0, 32'd32, 32'd0);
        load_all(32, 1, 1'b1);
        addr1 = 32'h0000_000F; #1;
        checks++; if (dataIn1 !== col_word(1, 31)) begin errors++; $display("FAIL wrap_hit: got %0d exp %0d", dataIn1, col_word(1, 31)); end
        addr1 = 32'h0000_0010; #1;
        checks++; if (dataIn1 !== MISS) begin errors++; $display("FAIL wrap_miss: got %0d exp 99999", dataIn1); end
        addr1 = 32'hFFFF_FFF0; #1;
        checks++; if (dataIn1 !== col_word(1, 0)) begin errors++; $display("FAIL wrap_base: got %0d exp %0d", dataIn1, col_word(1, 0)); end
        addr1 = 32'hFFFF_FFEF; #1;
        checks++; if (dataIn1 !== MISS) begin errors++; $display("FAIL wrap_below: got %0d exp 99999", dataIn1); end
    endtask

    initial begin
        test_reset();
        test_bad_cfg();
        test_basic();
        test_misses();
        test_reset_midload();
        test_ld_last_err();
        test_counters();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hht_mem_responder.md
HHT_MEM_RESPONDER -- requirements
Module: hht_mem_responder

Interface
REQ-001 The module SHALL expose these parameters, one per line:
- COL_DEPTH, 512, column-bank capacity in words.
- V_DEPTH, 32, vector-bank capacity in words.
- MISS_VAL, 32'd99999, read value for any unmapped or not-ready access.

REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- Clk, in, 1: single clock; all state updates on rising edge.
- Rst, in, 1: asynchronous, active-high reset.
- cfg_we, in, 1: latch col_base, v_base and col_size; start a load.
- col_base, in, 32: first address of the column window.
- v_base, in, 32: first address of the vector window.
- col_size, in, 32: number of column words (1..COL_DEPTH).
- ld_valid, in, 1: load beat offered.
- ld_ready, out, 1: load beat accepted when ld_valid & ld_ready.
- ld_data, in, 32: load word.
- ld_last, in, 1: marks the final beat of the vector load.
- ready, out, 1: high in SERVE.
- addr1, in, 32 / dataIn1, out, 32: column read port.
- addr2, in, 32 / dataIn2, out, 32: vector read port.
- rd_cnt1, out, 16: count of column-port hits.
- rd_cnt2, out, 16: count of vector-port hits.
- err, out, 1: sticky configuration or load error.

Function
REQ-003 The FSM SHALL have states IDLE, LD_COL, LD_V, SERVE and reset to IDLE.
REQ-004 cfg_we in IDLE or SERVE with 1 <= col_size <= COL_DEPTH SHALL latch all three config inputs, clear the write pointer and both counters, clear err, and go to LD_COL next cycle.
REQ-005 cfg_we with col_size == 0 or col_size > COL_DEPTH SHALL set err=1, move to IDLE, and leave the config registers unchanged.
REQ-006 cfg_we in LD_COL or LD_V SHALL be ignored.
REQ-007 ld_ready SHALL be 1 in LD_COL and LD_V only, combinationally from the state.
REQ-008 Each accepted beat in LD_COL SHALL write col_mem[wptr] and increment wptr; the beat with wptr == col_size-1 SHALL clear wptr and move to LD_V.
REQ-009 Each accepted beat in LD_V SHALL write v_mem[wptr] and increment wptr; the beat with wptr == V_DEPTH-1 SHALL move to SERVE.
REQ-010 ld_last on any beat other than the final LD_V beat SHALL set err=1 (the beat is still written); a final LD_V beat without ld_last SHALL also set err=1.
REQ-011 ld_valid=0 SHALL stall the load with no state or pointer change, for any number of cycles.
REQ-012 Reads SHALL be combinational, with zero-cycle latency (data valid in the same cycle as the address).
- In SERVE, when (addr1 - col_base) < col_size (32-bit unsigned subtraction, so the check is wrap-safe): dataIn1 = col_mem[addr1 - col_base].
- Otherwise dataIn1 = MISS_VAL.
REQ-013 In SERVE, when (addr2 - v_base) < V_DEPTH: dataIn2 = v_mem[addr2 - v_base]; otherwise dataIn2 = MISS_VAL.
REQ-014 Outside SERVE, dataIn1 and dataIn2 SHALL equal MISS_VAL for every address.
REQ-015 rd_cnt1 and rd_cnt2 SHALL each increment by 1 on every SERVE clock edge where their port hits, and SHALL saturate at 16'hFFFF.
REQ-016 Both ports hitting in the same cycle SHALL increment both counters; both ports reading the same address SHALL each return the correct data.
REQ-017 The two windows SHALL be independent; overlapping address ranges are legal, and each port decodes only its own window.
REQ-018 cfg_we in SERVE (legal col_size) SHALL drop ready on the next cycle; the memory contents are retained until overwritten.

Reset
REQ-019 Asserting Rst at any time, including mid-load, SHALL immediately force all of the following:
- state = IDLE, ready = 0, ld_ready = 0, err = 0;
- rd_cnt1 = rd_cnt2 = 0;
- wptr = 0;
- col_base = col_size = v_base = 0;
- dataIn1 = dataIn2 = MISS_VAL.
REQ-020 Memory contents SHALL NOT be reset; they become readable only after a complete new load.

Verification
REQ-021 Directed scenarios the bench SHALL cover:
- Basic load and read: cfg col_base=340, col_size=307, v_base=2; load 307 column words (first word 29, last word 14), then 32 vector words (first 85, last 65) with ld_last on the final beat -> ready=1, err=0. Then addr1=340 -> 29; addr1=646 -> 14; addr2=2 -> 85; addr2=33 -> 65.
- Misses: addr1=339, addr1=647, addr2=1 and addr2=34 -> 99999 on the respective port, and neither counter changes.
- Bad config: cfg_we with col_size=0 -> err=1, state IDLE; then cfg_we with col_size=513 -> err=1, state IDLE.
- Reset mid-load: Rst pulsed after 100 column beats -> ld_ready=0, dataIn1=99999; a fresh full load then reads correct data.
- Counters: 10 cycles with both ports hitting -> rd_cnt1=rd_cnt2=10; forcing an over-limit hit count -> counters hold at 16'hFFFF.
- Wrap-around: col_base=32'hFFFF_FFF0, col_size=32 -> addr1=32'h0000_000F hits col_mem[31], and addr1=32'h0000_0010 -> 99999.
